// File: rtl/heap_array_allocator.sv
// Shared hardware heap: NArrays arrays of NArea elements, LIFO recycling of freed ids,
// per-array length tracking and a one-move-per-cycle insert-with-shift.
// Optional feature macro: HEAP_ALLOC_CHECK_EN (allocated bitmap and access checking).
module heap_array_allocator #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NArea              = 7,
  parameter int unsigned NArrays            = 4,
  localparam int unsigned IW = (NArrays > 2) ? $clog2(NArrays) : 1,
  localparam int unsigned XW = $clog2(NArea + 1)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic [2:0]                    reqOp,
  input  logic [IW-1:0]                 reqArray,
  input  logic [XW-1:0]                 reqIndex,
  input  logic [MemoryElementWidth-1:0] reqData,
  output logic                          respValid,
  output logic [MemoryElementWidth-1:0] respData,
  output logic                          respError,
  output logic [IW:0]                   allocs
);

  localparam int unsigned W    = MemoryElementWidth;
  localparam int unsigned CW   = IW + 1;
  localparam int unsigned PW   = XW + 1;
  localparam int unsigned AW   = IW + XW;
  localparam int unsigned NTOT = NArrays * NArea;

  localparam logic [2:0] OP_ALLOC  = 3'd0;
  localparam logic [2:0] OP_FREE   = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_SIZE   = 3'd4;
  localparam logic [2:0] OP_INSERT = 3'd5;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [W-1:0]    heap_q  [NTOT];
  logic [W-1:0]    heap_d  [NTOT];
  logic [XW-1:0]   size_q  [NArrays];
  logic [XW-1:0]   size_d  [NArrays];
  logic [IW-1:0]   stack_q [NArrays];
  logic [IW-1:0]   stack_d [NArrays];
  logic [CW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   allocs_q, allocs_d;
  logic [IW-1:0]   sh_arr_q, sh_arr_d;
  logic [XW-1:0]   sh_idx_q, sh_idx_d;
  logic [XW-1:0]   sh_pos_q, sh_pos_d;
  logic [W-1:0]    sh_data_q, sh_data_d;
  logic            resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_data_q, resp_data_d;
  logic            resp_error_q, resp_error_d;

  logic            arr_ok_c, idx_ok_c, in_range_c, chk_bad_c;
  logic [XW-1:0]   cur_size_c, wr_size_c;
  logic [PW-1:0]   idx_p1_c, pos_p1_c;
  logic [AW-1:0]   req_addr_c, sh_addr_c;
  logic [IW-1:0]   alloc_id;
  logic            alloc_ok;

  // Ids only fall outside the array range when NArrays is not a power of two
  if (NArrays == (1 << IW)) begin : g_arr_full
    assign arr_ok_c = 1'b1;
  end else begin : g_arr_part
    assign arr_ok_c = (CW'(reqArray) < CW'(NArrays));
  end

  assign idx_ok_c   = (reqIndex < XW'(NArea));
  assign in_range_c = arr_ok_c && idx_ok_c;
  assign cur_size_c = size_q[reqArray];
  assign req_addr_c = AW'(reqArray) * AW'(NArea) + AW'(reqIndex);
  assign sh_addr_c  = AW'(sh_arr_q) * AW'(NArea) + AW'(sh_pos_q);
  assign idx_p1_c   = {1'b0, reqIndex} + PW'(1);
  assign pos_p1_c   = {1'b0, sh_pos_q} + PW'(1);
  assign wr_size_c  = (idx_p1_c > {1'b0, cur_size_c}) ? XW'(idx_p1_c) : cur_size_c;

`ifdef HEAP_ALLOC_CHECK_EN
  logic [NArrays-1:0] alloc_q, alloc_d;
  logic               arr_alloc_c;

  assign arr_alloc_c = arr_ok_c && alloc_q[reqArray];

  // Requests rejected without side effects when checking is enabled
  always_comb begin
    chk_bad_c = 1'b0;
    case (reqOp)
      OP_FREE, OP_SIZE:   chk_bad_c = !arr_alloc_c;
      OP_READ, OP_WRITE:  chk_bad_c = !arr_alloc_c || !idx_ok_c;
      OP_INSERT:          chk_bad_c = !arr_alloc_c || !idx_ok_c || (cur_size_c == XW'(NArea));
      default:            chk_bad_c = 1'b0;
    endcase
  end
`else
  assign chk_bad_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    heap_d       = heap_q;
    size_d       = size_q;
    stack_d      = stack_q;
    sp_d         = sp_q;
    allocs_d     = allocs_q;
    sh_arr_d     = sh_arr_q;
    sh_idx_d     = sh_idx_q;
    sh_pos_d     = sh_pos_q;
    sh_data_d    = sh_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    alloc_id     = '0;
    alloc_ok     = 1'b0;
`ifdef HEAP_ALLOC_CHECK_EN
    alloc_d      = alloc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          resp_valid_d = 1'b1;
          case (reqOp)
            OP_ALLOC: begin
              if (sp_q != '0) begin
                alloc_id = stack_q[IW'(sp_q - CW'(1))];
                sp_d     = sp_q - CW'(1);
                alloc_ok = 1'b1;
              end else if (allocs_q < CW'(NArrays)) begin
                alloc_id = IW'(allocs_q);
                allocs_d = allocs_q + CW'(1);
                alloc_ok = 1'b1;
              end
              if (alloc_ok) begin
                size_d[alloc_id] = '0;
                resp_data_d      = W'(alloc_id);
`ifdef HEAP_ALLOC_CHECK_EN
                alloc_d[alloc_id] = 1'b1;
`endif
              end else begin
                resp_error_d = 1'b1;
              end
            end
            OP_FREE: begin
              if (chk_bad_c) begin
                resp_error_d = 1'b1;
              end else begin
`ifdef HEAP_ALLOC_CHECK_EN
                alloc_d[reqArray] = 1'b0;
`endif
                if (sp_q < CW'(NArrays)) begin
                  stack_d[IW'(sp_q)] = reqArray;
                  sp_d               = sp_q + CW'(1);
                end
              end
            end
            OP_READ: begin
              if (chk_bad_c) resp_error_d = 1'b1;
              else if (in_range_c) resp_data_d = heap_q[req_addr_c];
            end
            OP_WRITE: begin
              if (chk_bad_c) begin
                resp_error_d = 1'b1;
              end else if (in_range_c) begin
                heap_d[req_addr_c] = reqData;
                size_d[reqArray]   = wr_size_c;
              end
            end
            OP_SIZE: begin
              if (chk_bad_c) resp_error_d = 1'b1;
              else resp_data_d = W'(cur_size_c);
            end
            OP_INSERT: begin
              if (chk_bad_c) begin
                resp_error_d = 1'b1;
              end else if (reqIndex >= cur_size_c) begin
                if (in_range_c) begin
                  heap_d[req_addr_c] = reqData;
                  size_d[reqArray]   = wr_size_c;
                end
              end else begin
                // Response deferred until the last move of the shift
                resp_valid_d = 1'b0;
                state_d      = S_SHIFT;
                sh_arr_d     = reqArray;
                sh_idx_d     = reqIndex;
                sh_pos_d     = cur_size_c - XW'(1);
                sh_data_d    = reqData;
              end
            end
            default: resp_error_d = 1'b1;
          endcase
        end
      end
      S_SHIFT: begin
        // The element in the last slot of a full array has nowhere to go and is dropped
        if (pos_p1_c < PW'(NArea)) heap_d[sh_addr_c + AW'(1)] = heap_q[sh_addr_c];
        if (sh_pos_q == sh_idx_q) begin
          heap_d[sh_addr_c] = sh_data_q;
          if (size_q[sh_arr_q] != XW'(NArea)) size_d[sh_arr_q] = size_q[sh_arr_q] + XW'(1);
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          sh_pos_d = sh_pos_q - XW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      for (int i = 0; i < int'(NTOT); i++) heap_q[i] <= '0;
      for (int i = 0; i < int'(NArrays); i++) begin
        size_q[i]  <= '0;
        stack_q[i] <= '0;
      end
      sp_q         <= '0;
      allocs_q     <= '0;
      sh_arr_q     <= '0;
      sh_idx_q     <= '0;
      sh_pos_q     <= '0;
      sh_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
`ifdef HEAP_ALLOC_CHECK_EN
      alloc_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      heap_q       <= heap_d;
      size_q       <= size_d;
      stack_q      <= stack_d;
      sp_q         <= sp_d;
      allocs_q     <= allocs_d;
      sh_arr_q     <= sh_arr_d;
      sh_idx_q     <= sh_idx_d;
      sh_pos_q     <= sh_pos_d;
      sh_data_q    <= sh_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
`ifdef HEAP_ALLOC_CHECK_EN
      alloc_q      <= alloc_d;
`endif
    end
  end

  assign reqReady  = ready_q;
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign respError = resp_error_q;
  assign allocs    = allocs_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// Scoreboard bench for heap_array_allocator: directed requests push expected responses,
// a monitor pops and compares data, error flag and response cycle.
module tb_heap_array_allocator;

  localparam logic [2:0] OP_ALLOC  = 3'd0;
  localparam logic [2:0] OP_FREE   = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_SIZE   = 3'd4;
  localparam logic [2:0] OP_INSERT = 3'd5;

  logic        clock, resetN, reqValid, reqReady;
  logic [2:0]  reqOp;
  logic [1:0]  reqArray;
  logic [2:0]  reqIndex;
  logic [11:0] reqData;
  logic        respValid, respError;
  logic [11:0] respData;
  logic [2:0]  allocs;

  typedef struct {
    logic [11:0] data;
    logic        err;
    bit          chk;
    int          edge_n;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  heap_array_allocator #(.MemoryElementWidth(12), .NArea(7), .NArrays(4)) dut (
    .clock(clock), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqArray(reqArray), .reqIndex(reqIndex), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respError(respError), .allocs(allocs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (resetN && respValid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got data=%0h err=%0b at edge %0d, required no response",
                 respData, respError, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (respError !== e.err || (e.chk && respData !== e.data) || cyc != e.edge_n) begin
          n_fail++;
          $display("FAIL %s: got data=%0h err=%0b edge=%0d, required data=%0h err=%0b edge=%0d",
                   e.nm, respData, respError, cyc, e.data, e.err, e.edge_n);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input int arr, input int idx, input int dat,
                       input int exp_data, input bit exp_err, input bit chk, input int k,
                       input bit push, input string nm);
    int g;
    exp_t e;
    @(negedge clock);
    reqValid = 1'b1;
    reqOp    = op;
    reqArray = 2'(arr);
    reqIndex = 3'(idx);
    reqData  = 12'(dat);
    g = 0;
    while (!reqReady && g < 64) begin
      @(negedge clock);
      g++;
    end
    if (!reqReady) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: request not accepted within 64 cycles, required acceptance", nm);
    end else if (push) begin
      e.data = 12'(exp_data); e.err = exp_err; e.chk = chk; e.edge_n = cyc + 1 + k; e.nm = nm;
      sb.push_back(e);
    end
    @(posedge clock);
    #1 reqValid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 64) begin
      @(negedge clock);
      g++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic al(input int id, input string nm);
    issue(OP_ALLOC, 0, 0, 0, id, 1'b0, 1'b1, 0, 1'b1, nm);
  endtask
  task automatic fr(input int arr, input bit err, input string nm);
    issue(OP_FREE, arr, 0, 0, 0, err, 1'b1, 0, 1'b1, nm);
  endtask
  task automatic wr(input int arr, input int idx, input int dat, input string nm);
    issue(OP_WRITE, arr, idx, dat, 0, 1'b0, 1'b0, 0, 1'b1, nm);
  endtask
  task automatic rd(input int arr, input int idx, input int exp_data, input string nm);
    issue(OP_READ, arr, idx, 0, exp_data, 1'b0, 1'b1, 0, 1'b1, nm);
  endtask
  task automatic sz(input int arr, input int exp_size, input string nm);
    issue(OP_SIZE, arr, 0, 0, exp_size, 1'b0, 1'b1, 0, 1'b1, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b0; reqValid = 1'b0; reqOp = '0; reqArray = '0; reqIndex = '0; reqData = '0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    check("rst_ready", int'(reqReady), 1);
    check("rst_valid", int'(respValid), 0);
    check("rst_allocs", int'(allocs), 0);
    check("rst_data", int'(respData), 0);

    // Fresh ids then recycling of a freed id
    al(0, "alloc0"); al(1, "alloc1"); al(2, "alloc2");
    drain();
    check("allocs_after3", int'(allocs), 3);
    fr(1, 1'b0, "free1");
    al(1, "realloc1");
    drain();
    check("allocs_still3", int'(allocs), 3);

    // Exhaustion and LIFO order
    al(3, "alloc3");
    issue(OP_ALLOC, 0, 0, 0, 0, 1'b1, 1'b1, 0, 1'b1, "alloc_exhausted");
    fr(2, 1'b0, "free2"); fr(3, 1'b0, "free3");
    al(3, "lifo_first"); al(2, "lifo_second");
    drain();
    check("allocs_high_water", int'(allocs), 4);

    // Write grows size, read-after-write, untouched element reads reset value
    wr(0, 2, 7, "wr_0_2");
    sz(0, 3, "size0_after_wr");
    rd(0, 2, 7, "rd_0_2");
    rd(0, 0, 0, "rd_0_0_cleared");
    wr(1, 0, 12'h5A, "wr_1_0");
    rd(1, 0, 12'h5A, "rd_after_wr");

    // Insert with a 3-move shift; the following read must wait for it
    wr(0, 0, 1, "fill0_0"); wr(0, 1, 2, "fill0_1"); wr(0, 2, 3, "fill0_2");
    issue(OP_INSERT, 0, 0, 9, 0, 1'b0, 1'b0, 3, 1'b1, "insert_shift3");
    rd(0, 0, 9, "ins_rd0"); rd(0, 1, 1, "ins_rd1"); rd(0, 2, 2, "ins_rd2"); rd(0, 3, 3, "ins_rd3");
    sz(0, 4, "ins_size");

    // Insert at the end behaves as a single-cycle write
    issue(OP_INSERT, 2, 0, 12'h33, 0, 1'b0, 1'b0, 0, 1'b1, "insert_append");
    sz(2, 1, "append_size");
    rd(2, 0, 12'h33, "append_rd");

    // Full array
    for (int i = 0; i < 7; i++) wr(1, i, 10 + i, "fill1");
    sz(1, 7, "full_size");
`ifdef HEAP_ALLOC_CHECK_EN
    issue(OP_INSERT, 1, 5, 12'h77, 0, 1'b1, 1'b0, 0, 1'b1, "insert_full_err");
    rd(1, 5, 15, "full_unchanged5");
    rd(1, 6, 16, "full_unchanged6");
`else
    issue(OP_INSERT, 1, 5, 12'h77, 0, 1'b0, 1'b0, 2, 1'b1, "insert_full_shift");
    rd(1, 4, 14, "full_rd4");
    rd(1, 5, 12'h77, "full_rd5");
    rd(1, 6, 15, "full_rd6_top_dropped");
`endif
    sz(1, 7, "full_size_after");

`ifdef HEAP_ALLOC_CHECK_EN
    fr(3, 1'b0, "free3_ok");
    fr(3, 1'b1, "double_free");
    issue(OP_WRITE, 0, 7, 12'h55, 0, 1'b1, 1'b0, 0, 1'b1, "wr_idx_oob");
    sz(0, 4, "size_after_oob");
    issue(OP_READ, 3, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1, "rd_unallocated");
`endif

    // Illegal opcodes
    issue(3'd6, 0, 0, 0, 0, 1'b1, 1'b1, 0, 1'b1, "illegal_op6");
    issue(3'd7, 0, 0, 0, 0, 1'b1, 1'b1, 0, 1'b1, "illegal_op7");
    sz(0, 4, "size_after_illegal");
    drain();

    // Reset two cycles into a 3-move insert: abandoned without response
    issue(OP_INSERT, 0, 1, 12'h44, 0, 1'b0, 1'b0, 3, 1'b0, "insert_abandoned");
    @(posedge clock);
    @(posedge clock);
    #1 resetN = 1'b0;
    @(negedge clock);
    check("mid_reset_valid", int'(respValid), 0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    check("post_reset_ready", int'(reqReady), 1);
    check("post_reset_allocs", int'(allocs), 0);
    check("post_reset_valid", int'(respValid), 0);
    al(0, "post_reset_alloc");
    sz(0, 0, "post_reset_size");
    rd(0, 1, 0, "post_reset_heap_cleared");
    drain();
    check("post_reset_allocs1", int'(allocs), 1);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/heap_array_allocator.md
# heap_array_allocator

Hardware heap for the zero-language array model. Holds `NArrays` arrays of `NArea` elements each, recycles freed array ids through a LIFO stack, and tracks each array's length. Supports a multi-cycle insert-with-shift. Sits between the instruction sequencer and heap storage, replacing the inline `array` / `mov` / heap update logic in generated fpga test programs with one shared, parametrised block.

## Interface
- `MemoryElementWidth`, 12: width of each heap element and of `reqData`/`respData`.
- `NArea`, 7: elements per array.
- `NArrays`, 4: maximum arrays. The id width `IW = max(1,$clog2(NArrays))`. The index/size width `XW = $clog2(NArea+1)`.
- `clock` input 1: the only clock. All state changes on the rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `reqValid` input 1: request present.
- `reqReady` output 1: block can accept a request. Resets to 1.
- `reqOp` input 3: 0 ALLOC, 1 FREE, 2 READ, 3 WRITE, 4 SIZE, 5 INSERT. Values 6–7 are illegal.
- `reqArray` input IW: array id.
- `reqIndex` input XW: element index.
- `reqData` input MemoryElementWidth: write/insert data.
- `respValid` output 1: one-cycle response pulse. There is no backpressure. Resets to 0.
- `respData` output MemoryElementWidth: allocated id, read data, or size, zero-extended. Resets to 0.
- `respError` output 1: qualified by `respValid`. Resets to 0.
- `allocs` output IW+1: high-water count of ids ever handed out. Resets to 0.

## Operation
- A request is accepted on a rising edge where `reqValid && reqReady`. Every accepted request produces exactly one `respValid` pulse.
- States:
  - IDLE: `reqReady`=1.
  - SHIFT: `reqReady`=0.
  - IDLE→SHIFT only on an accepted INSERT with `size > reqIndex`.
  - SHIFT→IDLE after the last move.
- ALLOC:
  - If the freed stack is non-empty, pop the top id.
  - Otherwise, if `allocs < NArrays`, return `allocs` and increment `allocs`.
  - Otherwise return `respError`=1 and `respData`=0.
  - The allocated array's size is set to 0. Element contents are not cleared.
- FREE: push `reqArray` onto the freed stack. `respData`=0.
- READ: `respData` = `heap[reqArray*NArea + reqIndex]`.
- WRITE:
  - Store `reqData` at that element.
  - Set `size = max(size, reqIndex+1)`.
- SIZE: `respData` = the size of `reqArray`.
- INSERT:
  - If `reqIndex >= size`, behave as WRITE (single cycle).
  - Otherwise move elements `size-1` down to `reqIndex` up by one, one element per cycle. Then store `reqData` at `reqIndex` and increment `size`.
  - If `size == NArea` beforehand, the top element is discarded and `size` stays at `NArea`.
- Freed stack depth is `NArrays`. A push onto a full stack is dropped.
- Size arithmetic saturates at `NArea`. All address arithmetic is unsigned, in `IW+XW` bits.
- Illegal `reqOp` returns `respError`=1 and has no side effects.
- Reset (any time, including during SHIFT):
  - Clears all heap elements, sizes, `allocs` and the stack pointer.
  - An in-flight INSERT is abandoned with no response.
  - State returns to IDLE.

## Timing
- Single-cycle ops: request accepted at edge N, `respValid` high during cycle N+1. Back-to-back requests are accepted every cycle.
- INSERT with shift:
  - `k = size - reqIndex` moves.
  - `reqReady` is low for k cycles after acceptance.
  - `respValid` is high in cycle N+k+1, together with `reqReady` returning to 1.
  - Total latency is k+1 cycles.
- A READ issued the cycle after a WRITE to the same element returns the new data.
- A request presented while `reqReady`=0 is not accepted and must be held by the requester.

## Configuration
- `HEAP_ALLOC_CHECK_EN` defined:
  - Keeps a per-array allocated bitmap.
  - These requests return `respError`=1 with no state change:
    - FREE of an unallocated id (double free).
    - READ/WRITE/SIZE/INSERT on an unallocated id.
    - `reqIndex >= NArea`.
    - `reqArray >= NArrays`.
    - INSERT into a full array.
- `HEAP_ALLOC_CHECK_EN` undefined:
  - No bitmap is kept.
  - `respError` is asserted only for ALLOC exhaustion and illegal `reqOp`.
  - For out-of-range or unallocated accesses the data result is unspecified, but the block must not hang and must respond with normal latency.

## Test plan
- Reset, then three ALLOCs: responses 0, 1, 2, `allocs`=3. FREE 1, then ALLOC: response 1, `allocs` still 3.
- With `NArrays`=4: five ALLOCs. The fifth returns `respError`=1, `respData`=0. FREE 2, FREE 3, then ALLOC twice: responses 3, then 2 (LIFO).
- WRITE array 0 index 2 data 7, then SIZE 0: response 3. READ index 2: 7. READ index 0: 0.
- Array 0 holds 1, 2, 3 (size 3). INSERT index 0 data 9: response in cycle N+4. READs return 9, 1, 2, 3. SIZE returns 4.
- With `HEAP_ALLOC_CHECK_EN`:
  - FREE of an already-freed id: `respError`=1.
  - WRITE index 7 with `NArea`=7: `respError`=1, size unchanged.
- Assert `resetN` low two cycles into a 3-move INSERT: no `respValid`. After release, `reqReady`=1, `allocs`=0, and SIZE 0 returns 0.
